// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//
// Drains a standard synchronous FIFO (read data valid one cycle after the read
// strobe) into a valid/ready byte stream cut into frames of FRAME_LEN bytes.
// A 2-entry skid buffer behind a registered output stage lets the block keep
// one byte per cycle while absorbing downstream back-pressure without losing
// the word that is already in flight from the FIFO.
//
// Optional feature (macro FIFO_READER_PAD_EN):
//   When defined, a frame stalled on an empty FIFO for PAD_TIMEOUT consecutive
//   cycles is completed with PAD_BYTE fillers (m_last on the final one). When
//   undefined, the PAD state and its timeout counter do not exist and a stalled
//   frame waits indefinitely for more data.
//
// Parameters:
//   N_BIT       data byte width
//   FRAME_LEN   bytes per output frame (2..65535)
//   PAD_TIMEOUT empty-FIFO cycles before padding (1..255)
//   PAD_BYTE    padding value
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   fifo_data  in   FIFO read data, valid the cycle after an accepted read
//   fifo_empty in   FIFO empty flag
//   fifo_rd    out  FIFO read strobe
//   m_data     out  stream data
//   m_valid    out  stream data valid
//   m_ready    in   downstream ready
//   m_last     out  last byte of frame (qualified by m_valid)
//   frame_cnt  out  completed frames, wraps 16'hFFFF -> 0
//   busy       out  high whenever the control state is not IDLE
// -----------------------------------------------------------------------------
module fifo_reader #(
  parameter int unsigned      N_BIT       = 8,
  parameter int unsigned      FRAME_LEN   = 16,
  parameter int unsigned      PAD_TIMEOUT = 8,
  parameter logic [N_BIT-1:0] PAD_BYTE    = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BIT-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic [N_BIT-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [15:0]      frame_cnt,
  output logic             busy
);

  // Elaboration-time range checks on the configuration.
  if (FRAME_LEN < 2 || FRAME_LEN > 65535) begin : g_bad_frame_len
    $error("fifo_reader: FRAME_LEN must be in 2..65535");
  end
  if (PAD_TIMEOUT < 1 || PAD_TIMEOUT > 255) begin : g_bad_pad_timeout
    $error("fifo_reader: PAD_TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
`ifdef FIFO_READER_PAD_EN
    STALL  = 2'd2,
    PAD    = 2'd3
`else
    STALL  = 2'd2
`endif
  } state_e;

  // Index of the final byte of a frame; both frame counters wrap here.
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  // Reset release synchroniser; activity is held off until both flops are set.
  logic [1:0]       rst_sync_q;

  state_e           state_q, state_d;
  logic [15:0]      issued_q, issued_d;     // reads (or pads) issued in current frame
  logic [15:0]      load_q, load_d;         // bytes loaded into the output stage in frame
  logic             inflight_q, inflight_d; // a read was issued last cycle
  logic [N_BIT-1:0] buf0_q, buf0_d;         // skid buffer head
  logic [N_BIT-1:0] buf1_q, buf1_d;         // skid buffer tail
  logic [1:0]       buf_cnt_q, buf_cnt_d;
  logic [N_BIT-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [15:0]      frame_q, frame_d;

  logic             run_s;
  logic             out_free_s;
  logic             xfer_s;
  logic             last_xfer_s;
  logic             rd_s;
  logic             pop_s;
  logic             bypass_s;
  logic             push_s;
  logic             pad_load_s;
  logic             load_s;
  logic             rd_block_s;
  logic [N_BIT-1:0] load_data_s;

`ifdef FIFO_READER_PAD_EN
  localparam logic [7:0] TO_LAST = 8'(PAD_TIMEOUT - 1);
  logic [7:0]       to_q, to_d;             // consecutive empty cycles while stalled
`endif

  assign run_s       = rst_sync_q[1];
  assign out_free_s  = !m_valid_q || m_ready;
  assign xfer_s      = m_valid_q && m_ready;
  assign last_xfer_s = xfer_s && m_last_q;

`ifdef FIFO_READER_PAD_EN
  // Once padding starts, real data must stay in the FIFO for the next frame.
  assign rd_block_s  = (state_q == PAD);
  assign pad_load_s  = (state_q == PAD) && (buf_cnt_q == 2'd0) && !inflight_q &&
                       out_free_s && (issued_q != 16'd0);
`else
  assign rd_block_s  = 1'b0;
  assign pad_load_s  = 1'b0;
`endif

  // The read strobe is combinational on fifo_empty so the first byte reaches
  // the output two cycles after the FIFO goes non-empty. Budgeting against
  // buffered + in-flight words guarantees the returning word always has a
  // free slot even if the output is stalled. The issued-in-frame counter wraps
  // at LAST_IDX, so it is always below FRAME_LEN and frame N+1 reads only
  // begin after frame N's last read.
  assign rd_s = run_s && !fifo_empty && !rd_block_s &&
                ((buf_cnt_q + {1'b0, inflight_q}) < 2'd2);

  // The oldest word wins the output stage: buffer head, then the word arriving
  // from the FIFO, then a pad filler.
  assign pop_s    = out_free_s && (buf_cnt_q != 2'd0);
  assign bypass_s = out_free_s && (buf_cnt_q == 2'd0) && inflight_q;
  assign push_s   = inflight_q && !bypass_s;
  assign load_s   = pop_s || bypass_s || pad_load_s;

  // Reset release synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
`ifdef FIFO_READER_PAD_EN
    to_d    = 8'd0;
`endif
    case (state_q)
      IDLE: begin
        if (rd_s) begin
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        // issued_q != 0 means a frame's reads are only partly issued.
        if (fifo_empty && (issued_q != 16'd0)) begin
          state_d = STALL;
        end else if (last_xfer_s && fifo_empty && (buf_cnt_q == 2'd0) && !inflight_q) begin
          state_d = IDLE;
        end else begin
          state_d = STREAM;
        end
      end
      STALL: begin
        if (!fifo_empty) begin
          state_d = STREAM;
`ifdef FIFO_READER_PAD_EN
        end else if (to_q == TO_LAST) begin
          state_d = PAD;
        end else begin
          state_d = STALL;
          to_d    = to_q + 8'd1;
`else
        end else begin
          state_d = STALL;
`endif
        end
      end
`ifdef FIFO_READER_PAD_EN
      PAD: begin
        // issued_q back at zero means the last filler has been loaded.
        if (last_xfer_s && (issued_q == 16'd0)) begin
          state_d = IDLE;
        end else begin
          state_d = PAD;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef FIFO_READER_PAD_EN
  // Pad timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_q <= 8'd0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  // Datapath next-state: counters, skid buffer, output stage, frame count.
  always_comb begin
    issued_d   = issued_q;
    load_d     = load_q;
    inflight_d = rd_s;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    buf_cnt_d  = buf_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    frame_d    = frame_q;

    if (pop_s) begin
      load_data_s = buf0_q;
    end else if (bypass_s) begin
      load_data_s = fifo_data;
    end else begin
      load_data_s = PAD_BYTE;
    end

    if (rd_s || pad_load_s) begin
      if (issued_q == LAST_IDX) begin
        issued_d = 16'd0;
      end else begin
        issued_d = issued_q + 16'd1;
      end
    end else begin
      issued_d = issued_q;
    end

    case ({pop_s, push_s})
      2'b10: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b01: begin
        if (buf_cnt_q == 2'd0) begin
          buf0_d = fifo_data;
        end else begin
          buf1_d = fifo_data;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = fifo_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data;
        end
      end
      default: begin
        buf_cnt_d = buf_cnt_q;
      end
    endcase

    if (load_s) begin
      m_data_d  = load_data_s;
      m_valid_d = 1'b1;
      m_last_d  = (load_q == LAST_IDX);
      if (load_q == LAST_IDX) begin
        load_d = 16'd0;
      end else begin
        load_d = load_q + 16'd1;
      end
    end else if (xfer_s) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end

    if (last_xfer_s) begin
      frame_d = frame_q + 16'd1;
    end else begin
      frame_d = frame_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_q   <= 16'd0;
      load_q     <= 16'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      buf_cnt_q  <= 2'd0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      frame_q    <= 16'd0;
    end else begin
      issued_q   <= issued_d;
      load_q     <= load_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      buf_cnt_q  <= buf_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      frame_q    <= frame_d;
    end
  end

  assign fifo_rd   = rd_s;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign frame_cnt = frame_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter N_BIT, default 8, data byte width.
REQ-002 SHALL have parameter FRAME_LEN, default 16, bytes per output frame (range 2..65535).
REQ-003 SHALL have parameter PAD_TIMEOUT, default 8, empty-FIFO cycles before padding (range 1..255).
REQ-004 SHALL have parameter PAD_BYTE, default 8'h00, padding value.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk  input  1  clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-008 SHALL have port fifo_data  input  N_BIT  FIFO read data, valid the cycle after an accepted read.
REQ-009 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-010 SHALL have port fifo_rd  output  1  FIFO read strobe; drives the FIFO read_val input.
REQ-011 SHALL have port m_data  output  N_BIT  stream data.
REQ-012 SHALL have port m_valid  output  1  stream data valid.
REQ-013 SHALL have port m_ready  input  1  downstream ready.
REQ-014 SHALL have port m_last  output  1  last byte of frame, qualified by m_valid.
REQ-015 SHALL have port frame_cnt  output  16  completed frames, wraps 16'hFFFF->0.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL complete a transfer on a cycle with m_valid=1 and m_ready=1.
REQ-018 SHALL assert fifo_rd only when fifo_empty=0, issued-in-frame < FRAME_LEN, and buffered words plus in-flight read < 2.
REQ-019 SHALL capture fifo_data exactly one cycle after fifo_rd=1 into a 2-entry skid buffer, with no word lost or duplicated.
REQ-020 SHALL keep m_data/m_valid/m_last stable while m_valid=1 and m_ready=0.
REQ-021 SHALL present the first byte of a frame on m_valid 2 cycles after fifo_empty falls in IDLE.
REQ-022 SHALL sustain one byte per cycle when fifo_empty=0 and m_ready=1 continuously.
REQ-023 SHALL assert m_last with the FRAME_LEN-th byte of each frame, then increment frame_cnt on that byte's transfer.
REQ-024 SHALL implement states IDLE, STREAM, STALL, PAD.
REQ-025 IDLE->STREAM on first fifo_rd; STREAM->STALL when fifo_empty=1 mid-frame; STALL->STREAM when fifo_empty=0; STREAM->IDLE on the m_last transfer.
REQ-026 SHALL, on the m_last transfer with fifo_empty=0, start the next frame in the same cycle without a bubble (STREAM held).
REQ-027 SHALL never issue reads belonging to frame N+1 before the last byte of frame N has been issued.

Reset
REQ-028 SHALL, with reset=0, immediately force state IDLE, fifo_rd=0, m_valid=0, m_last=0, m_data=0, frame_cnt=0, busy=0, and clear buffer, counters, and the in-flight flag.
REQ-029 SHALL discard any partial frame on reset mid-frame; the data of an in-flight read is dropped.
REQ-030 SHALL deassert reset synchronously internally (two-flop release) so the first fifo_rd occurs no earlier than 2 cycles after reset rises.

Configuration
REQ-031 SHALL, with macro FIFO_READER_PAD_EN defined, enter PAD from STALL after PAD_TIMEOUT consecutive empty cycles and emit PAD_BYTE for the remaining bytes of the frame (m_last on the final byte), then return to IDLE; data arriving during PAD stays in the FIFO for the next frame.
REQ-032 SHALL, without FIFO_READER_PAD_EN, omit the PAD state and timeout counter; STALL waits indefinitely.

Verification
REQ-033 SHALL verify 16 bytes 1..16 prefilled, m_ready=1 -> 16 consecutive beats 1..16, m_last on 16, frame_cnt=1.
REQ-034 SHALL verify m_ready toggling 1,0,0,1 during a frame -> no loss or duplication, data held stable while stalled, fifo_rd never over-reads.
REQ-035 SHALL verify 32 bytes prefilled -> two frames back-to-back, no bubble between byte 16 and 17, frame_cnt=2.
REQ-036 SHALL verify 5 bytes then empty, PAD_EN defined, PAD_TIMEOUT=8 -> 8 cycles after last read, 11 beats of 8'h00, m_last on the 16th beat overall.
REQ-037 SHALL verify the same stimulus without PAD_EN -> busy=1, m_valid=0 after 5 beats indefinitely; 11 more bytes written -> frame completes.
REQ-038 SHALL verify reset=0 at byte 7 of a frame -> all outputs zero at once; after release, the next frame starts with the next FIFO byte.
